signed_sum_accumulator: RTL and testbench



---
 rtl/signed_sum_accumulator.sv | 138 +++++++++++++
 tb/tb_signed_sum_accumulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_sum_accumulator.sv
// Frame accumulator behind the 4-bit overflow-flagging adder.
// Rebuilds exact sums, saturates per step, emits one total per frame.
module signed_sum_accumulator #(
  parameter int IN_W      = 4,
  parameter int ACC_W     = 6,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_ovf_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic [ACC_W-1:0] r_out_acc;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_out_ovf_cnt;

  logic [IN_W:0]    w_ext;
  logic [ACC_W:0]   w_ext_w;
  logic [ACC_W:0]   w_nxt;
  logic             w_hi;
  logic             w_lo;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_sat_nxt;
  logic [CNT_W-1:0] w_ovf_nxt;
  logic             w_take;
  logic             w_last;

  // An overflowed sum has lost its true sign bit; invert to restore it.
  assign w_ext = in_ovf ?
    {~in_sum[IN_W-1], in_sum} :
    { in_sum[IN_W-1], in_sum};

  assign w_ext_w =
    {{(ACC_W-IN_W){w_ext[IN_W]}}, w_ext};
  assign w_nxt =
    {r_acc[ACC_W-1], r_acc} + w_ext_w;

  // Top two bits disagree only when nxt left the ACC_W range.
  assign w_hi = ~w_nxt[ACC_W] &  w_nxt[ACC_W-1];
  assign w_lo =  w_nxt[ACC_W] & ~w_nxt[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_nxt[ACC_W-1:0];
    if (w_hi) w_acc_nxt = MAX;
    if (w_lo) w_acc_nxt = MIN;
  end

  assign w_sat_nxt = r_sat | w_hi | w_lo;
  assign w_ovf_nxt = r_ovf_cnt + CNT_W'(in_ovf);
  assign w_take    = in_valid & in_ready;
  assign w_last    = (r_cnt == LAST);

  assign in_ready    = (r_state == ACCUM);
  assign out_valid   = (r_state == HOLD);
  assign out_acc     = r_out_acc;
  assign out_sat     = r_out_sat;
  assign out_ovf_cnt = r_out_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ACCUM;
      r_acc         <= '0;
      r_sat         <= 1'b0;
      r_cnt         <= '0;
      r_ovf_cnt     <= '0;
      r_out_acc     <= '0;
      r_out_sat     <= 1'b0;
      r_out_ovf_cnt <= '0;
    end else if (clear) begin
      r_state       <= ACCUM;
      r_acc         <= '0;
      r_sat         <= 1'b0;
      r_cnt         <= '0;
      r_ovf_cnt     <= '0;
      r_out_acc     <= '0;
      r_out_sat     <= 1'b0;
      r_out_ovf_cnt <= '0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_take) begin
            r_acc     <= w_acc_nxt;
            r_sat     <= w_sat_nxt;
            r_ovf_cnt <= w_ovf_nxt;
            r_cnt     <= r_cnt + 1'b1;
            if (w_last) begin
              r_out_acc     <= w_acc_nxt;
              r_out_sat     <= w_sat_nxt;
              r_out_ovf_cnt <= w_ovf_nxt;
              r_state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state       <= ACCUM;
            r_acc         <= '0;
            r_sat         <= 1'b0;
            r_cnt         <= '0;
            r_ovf_cnt     <= '0;
            r_out_acc     <= '0;
            r_out_sat     <= 1'b0;
            r_out_ovf_cnt <= '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Bench for signed_sum_accumulator: table frames, corner
// sequences and random frames against an arithmetic model.
module tb_signed_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_sum = '0;
  logic       in_ovf = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_acc;
  logic       out_sat;
  logic [3:0] out_ovf_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  signed_sum_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_sat    (out_sat),
    .out_ovf_cnt(out_ovf_cnt)
  );

  typedef struct packed {
    logic [7:0][3:0] s;
    logic [7:0]      o;
    int              acc;
    int              sat;
    int              cnt;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d",
                  nm, act, exp);
  endtask

  // True value of a pair: the wrapped sum is off by 2^4 when ovf is set.
  function automatic int true_val(input logic [3:0] s,
                                  input logic o);
    int v;
    v = int'($signed(s));
    if (o) v = (v < 0) ? v + 16 : v - 16;
    return v;
  endfunction

  task automatic model(input logic [7:0][3:0] s,
                       input logic [7:0] o,
                       output int acc, output int sat,
                       output int cnt);
    acc = 0; sat = 0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      acc += true_val(s[i], o[i]);
      if (acc > 31)  begin acc = 31;  sat = 1; end
      if (acc < -32) begin acc = -32; sat = 1; end
      cnt += int'(o[i]);
    end
  endtask

  task automatic push(input logic [3:0] s,
                      input logic o);
    int t;
    t = 0;
    in_valid = 1'b1; in_sum = s; in_ovf = o;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_accept_valid", int'(out_valid), 0);
    chk("post_accept_ready", int'(in_ready), 1);
  endtask

  task automatic frame(input string nm,
                       input logic [7:0][3:0] s,
                       input logic [7:0] o,
                       input int ea, input int es,
                       input int ec, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2))
        @(posedge clk);
      #0 push(s[i], o[i]);
      if (i == 6)
        chk({nm, "_early_valid"}, int'(out_valid), 0);
    end
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_ready"}, int'(in_ready), 0);
    chk({nm, "_acc"}, int'($signed(out_acc)), ea);
    chk({nm, "_sat"}, int'(out_sat), es);
    chk({nm, "_cnt"}, int'(out_ovf_cnt), ec);
  endtask

  initial begin
    logic [7:0][3:0] s;
    logic [7:0]      o;
    int ea, es, ec;

    for (int i = 0; i < 8; i++) begin
      tbl[0].s[i] = 4'b0011; tbl[0].o[i] = 1'b0;
      tbl[1].s[i] = 4'b1000; tbl[1].o[i] = 1'b1;
      tbl[2].s[i] = (i < 2) ? 4'b0000 : 4'b0001;
      tbl[2].o[i] = (i < 2);
      tbl[3].s[i] = (i < 3) ? 4'b0000 : 4'b0001;
      tbl[3].o[i] = (i < 3);
    end
    tbl[0].acc = 24;  tbl[0].sat = 0; tbl[0].cnt = 0;
    tbl[1].acc = 31;  tbl[1].sat = 1; tbl[1].cnt = 8;
    tbl[2].acc = -26; tbl[2].sat = 0; tbl[2].cnt = 2;
    tbl[3].acc = -27; tbl[3].sat = 1; tbl[3].cnt = 3;

    #2;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_acc", int'(out_acc), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_cnt", int'(out_ovf_cnt), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      frame($sformatf("tbl%0d", k), tbl[k].s, tbl[k].o,
            tbl[k].acc, tbl[k].sat, tbl[k].cnt, 1'b0);
      accept();
    end

    // asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) push(4'b0101, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("amid_ready", int'(in_ready), 1);
    chk("amid_valid", int'(out_valid), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    frame("after_rst", tbl[0].s, tbl[0].o,
          24, 0, 0, 1'b0);

    // back-pressure with in_valid held
    in_valid = 1'b1; in_sum = 4'b0111; in_ovf = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_acc", int'($signed(out_acc)), 24);
      chk("bp_cnt", int'(out_ovf_cnt), 0);
    end
    in_valid = 1'b0;
    accept();
    for (int i = 0; i < 8; i++) begin
      s[i] = 4'b0111; o[i] = 1'b1;
    end
    frame("bp_next", s, o, -32, 1, 8, 1'b0);

    // clear in HOLD discards the result
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_ready", int'(in_ready), 1);

    // clear drops a simultaneous handshake
    in_valid = 1'b1; in_sum = 4'b0111; in_ovf = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s[i] = 4'b0001; o[i] = 1'b0;
    end
    frame("clr_next", s, o, 8, 0, 0, 1'b0);
    accept();

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 8; i++) begin
        s[i] = 4'($urandom_range(0, 15));
        o[i] = 1'($urandom_range(0, 1));
      end
      model(s, o, ea, es, ec);
      frame($sformatf("rnd%0d", f), s, o,
            ea, es, ec, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_hold", int'($signed(out_acc)), ea);
      end
      accept();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
